nibble_serial_adder: RTL
========================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter: WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
REQ-002 The block SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port: in_valid  input  1  operand set a/b/cin is valid.
REQ-005 The block SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 The block SHALL have ports: a, b  input  WIDTH  unsigned operands.
REQ-007 The block SHALL have port: cin  input  1  carry-in to bit 0.
REQ-008 The block SHALL have port: out_valid  output  1  result is valid.
REQ-009 The block SHALL have port: out_ready  input  1  downstream accepts result.
REQ-010 The block SHALL have port: sum  output  WIDTH  a+b+cin, modulo 2^WIDTH.
REQ-011 The block SHALL have port: carry  output  1  carry out of bit WIDTH-1.

Function
REQ-012 The block SHALL compute {carry,sum} = a+b+cin one 4-bit nibble per cycle, LSB nibble first, with NIBBLES = WIDTH/4.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 In IDLE: in_ready=1 and out_valid=0; on in_valid=1 at an edge it SHALL capture a, b, cin, clear the nibble index, and go to RUN.
REQ-015 In RUN: each cycle it SHALL add nibble k of a and b plus the carry register, write sum nibble k, update the carry register, and increment k.
REQ-016 When the last nibble (k=NIBBLES-1) is processed, the FSM SHALL go to DONE.
REQ-017 out_valid SHALL rise exactly NIBBLES clock edges after the accepting edge.
REQ-018 In DONE: out_valid=1, and sum/carry SHALL be held stable until out_ready=1 at an edge, after which the FSM returns to IDLE.
REQ-019 If out_ready=1 in the first DONE cycle, the handshake SHALL complete in that cycle.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid and operand changes in those states SHALL be ignored.
REQ-021 Back-to-back operation SHALL give a minimum spacing of NIBBLES+2 cycles between input handshakes.
REQ-022 For WIDTH=4, RUN SHALL last exactly one cycle.
REQ-023 sum and carry SHALL retain their last values in IDLE.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE, in_ready=1, out_valid=0, sum=0, carry=0, nibble index=0, carry register=0.
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation, and no out_valid SHALL be produced for it.
REQ-026 Reset release SHALL be synchronised by the integrator; the block SHALL not add a synchroniser.

Configuration
REQ-027 With macro NSA_OVERFLOW_EN defined, the block SHALL add port ovf  output  1: two's-complement signed overflow of the full-width add.
REQ-028 ovf SHALL equal the carry into bit WIDTH-1 XOR carry, SHALL be valid with out_valid, and SHALL reset to 0.
REQ-029 Without NSA_OVERFLOW_EN, the ovf port and its logic SHALL be absent.

Structure
REQ-030 Package nsa_pkg SHALL hold the state enum (IDLE/RUN/DONE), the constant NIBBLE_W=4, and the parameter-legality check function.
REQ-031 One sub-module, nsa_nibble_add, SHALL be used: a combinational 4-bit + carry-in adder producing a 4-bit sum and carry-out, instantiated once.
REQ-032 An illegal WIDTH (not a multiple of 4, or <4) SHALL cause an elaboration error.

Verification
REQ-033 The bench SHALL cover: WIDTH=16, a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, carry=1, with out_valid high 4 edges after acceptance.
REQ-034 The bench SHALL cover: a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, carry=0.
REQ-035 The bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> sum/carry/out_valid stable, in_ready=0 throughout; handshake completes on the 6th cycle.
REQ-036 The bench SHALL cover: rst_n pulsed low during the 2nd RUN cycle -> immediate IDLE, sum=0, out_valid never asserted; the next operation computes correctly.
REQ-037 The bench SHALL cover: WIDTH=4, a=4'hF, b=4'hF, cin=1 -> sum=4'hF, carry=1, with out_valid 1 edge after acceptance.
REQ-038 The bench SHALL cover: with NSA_OVERFLOW_EN, a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, ovf=1, carry=0; and a=16'hFFFF, b=16'h0001 -> ovf=0.

Source files
------------

// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the FSM state enum, the nibble width and the WIDTH legality check.
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_e;

  function automatic bit width_legal(input int w);
    return (w >= NIBBLE_W) && ((w % NIBBLE_W) == 0);
  endfunction

endpackage

// File: rtl/nsa_nibble_add.sv
// Combinational 4-bit adder with carry-in and carry-out; the single datapath
// slice reused by the serial adder every RUN cycle.
module nsa_nibble_add
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial adder: {carry,sum} = a+b+cin, one nibble per cycle, LSB nibble first.
// Define NSA_OVERFLOW_EN to add the signed-overflow output ovf.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef NSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  generate
    if (!width_legal(WIDTH)) begin : g_width_check
      $error("nibble_serial_adder: WIDTH=%0d must be a multiple of 4 and >= 4", WIDTH);
    end
  endgenerate

  nsa_state_e          state_reg, state_next;
  logic [KW-1:0]       k_reg;
  logic [WIDTH-1:0]    opa_reg, opb_reg;
  logic                c_reg;
  logic                carry_reg;
  logic [NIBBLE_W-1:0] sum_nib_reg [NIBBLES];
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_co;

  // Operands shift right each RUN cycle so the adder always sees bits [3:0].
  nsa_nibble_add u_nibble_add (
    .a  (opa_reg[NIBBLE_W-1:0]),
    .b  (opb_reg[NIBBLE_W-1:0]),
    .ci (c_reg),
    .s  (nib_s),
    .co (nib_co)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (k_reg == K_LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      c_reg     <= 1'b0;
      carry_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            opa_reg <= a;
            opb_reg <= b;
            c_reg   <= cin;
            k_reg   <= '0;
          end
        end
        RUN: begin
          opa_reg <= opa_reg >> NIBBLE_W;
          opb_reg <= opb_reg >> NIBBLE_W;
          c_reg   <= nib_co;
          k_reg   <= k_reg + KW'(1);
          if (k_reg == K_LAST) carry_reg <= nib_co;
        end
        default: ;
      endcase
    end
  end

  // Each result nibble has its own register, loaded only in its own RUN cycle.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_sum
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        sum_nib_reg[gi] <= '0;
      else if (state_reg == RUN && k_reg == KW'(gi))
        sum_nib_reg[gi] <= nib_s;
    end
    assign sum[gi*NIBBLE_W +: NIBBLE_W] = sum_nib_reg[gi];
  end

`ifdef NSA_OVERFLOW_EN
  logic ovf_reg;
  // Carry into the MSB is recovered from the top nibble's operand and sum bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_reg <= 1'b0;
    else if (state_reg == RUN && k_reg == K_LAST)
      ovf_reg <= opa_reg[NIBBLE_W-1] ^ opb_reg[NIBBLE_W-1] ^ nib_s[NIBBLE_W-1] ^ nib_co;
  end
  assign ovf = ovf_reg;
`endif

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign carry     = carry_reg;

endmodule
